ex_simple_pipe: RTL and testbench

Parametrised, registered execution unit for the "simple" functional unit. It sits between the simple reservation station and the ROB/register-file writeback. Each cycle it picks one operand-ready entry from `NUM_SLOTS` candidate RS slots using a round-robin arbiter, evaluates it in the shared `alu`, and holds the result in an output register. The ROB drains that register through a valid/ready handshake. The block adds back-pressure, flush handling and fair arbitration over N slots.

---
 rtl/ex_pkg.sv | 52 +++++
 rtl/alu.sv | 36 +++
 rtl/ex_simple_pipe_rr_arbiter.sv | 34 +++
 rtl/ex_simple_pipe.sv | 147 ++++++++++++++
 tb/tb_ex_simple_pipe.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared execution-unit definitions: ALU opcodes and RS entry field offsets.
// Offsets are functions of XLEN/REG_ADDR_W so every FU decodes entries identically.
package ex_pkg;

    localparam int ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'd9;

    // Layout LSB->MSB: rd, src1_valid, src1, src2_valid, src2, regwrite,
    // branch, memtoreg, memread, memwrite, aluop.
    function automatic int entry_width(input int xlen, input int reg_addr_w);
        return 5 + 5 + 2 * (xlen + 1) + reg_addr_w;
    endfunction

    function automatic int src1_valid_bit(input int xlen, input int reg_addr_w);
        return reg_addr_w + 0 * xlen;
    endfunction

    function automatic int src1_lsb(input int xlen, input int reg_addr_w);
        return reg_addr_w + 1 + 0 * xlen;
    endfunction

    function automatic int src2_valid_bit(input int xlen, input int reg_addr_w);
        return reg_addr_w + 1 + xlen;
    endfunction

    function automatic int src2_lsb(input int xlen, input int reg_addr_w);
        return reg_addr_w + 2 + xlen;
    endfunction

    function automatic int regwrite_bit(input int xlen, input int reg_addr_w);
        return reg_addr_w + 2 + 2 * xlen;
    endfunction

    function automatic int memwrite_bit(input int xlen, input int reg_addr_w);
        return reg_addr_w + 6 + 2 * xlen;
    endfunction

    function automatic int aluop_lsb(input int xlen, input int reg_addr_w);
        return reg_addr_w + 7 + 2 * xlen;
    endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational ALU used by the simple functional unit.
module alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ALU_OP_W-1:0] aluop,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    output logic [XLEN-1:0]     result
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] shamt_s;
    assign shamt_s = src2[SHAMT_W-1:0];

    // Opcode decode; unknown opcodes yield zero.
    always_comb begin
        result = '0;
        case (aluop)
            ALU_ADD:  result = src1 + src2;
            ALU_SUB:  result = src1 - src2;
            ALU_AND:  result = src1 & src2;
            ALU_OR:   result = src1 | src2;
            ALU_XOR:  result = src1 ^ src2;
            ALU_SLL:  result = src1 << shamt_s;
            ALU_SRL:  result = src1 >> shamt_s;
            ALU_SRA:  result = $unsigned($signed(src1) >>> shamt_s);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (src1 < src2)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_simple_pipe_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr (wrapping) wins when enabled.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic             grant_any,
    output logic [PTR_W-1:0] next_ptr
);

    int idx_s;

    // Scan from ptr; the found flag keeps only the first hit.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        next_ptr  = ptr;
        idx_s     = 0;
        for (int off = 0; off < N; off++) begin
            idx_s = (int'(ptr) + off) % N;
            if (en && !grant_any && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_any    = 1'b1;
                next_ptr     = PTR_W'((idx_s + 1) % N);
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/ex_simple_pipe.sv
// Simple FU execution stage: round-robin issue from RS slots, shared ALU,
// single registered result drained to the ROB via valid/ready.
module ex_simple_pipe
    import ex_pkg::*;
#(
    parameter int NUM_SLOTS  = 2,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ROB_IDX_W  = 4,
    parameter int ENTRY_W    = entry_width(XLEN, REG_ADDR_W)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SLOTS*ENTRY_W-1:0]   rs_entry,
    input  logic [NUM_SLOTS*ROB_IDX_W-1:0] rs_rob_idx,
    input  logic [NUM_SLOTS-1:0]           rs_occupied,
    output logic [NUM_SLOTS-1:0]           issue,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [XLEN+REG_ADDR_W:0]       executed_inst,
    output logic [ROB_IDX_W-1:0]           out_rob_idx,
    output logic [XLEN-1:0]                writeData,
    output logic [REG_ADDR_W-1:0]          writeAddr,
    output logic                           writeEn
);

    localparam int PTR_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int SRC1_V    = src1_valid_bit(XLEN, REG_ADDR_W);
    localparam int SRC1_LSB  = src1_lsb(XLEN, REG_ADDR_W);
    localparam int SRC2_V    = src2_valid_bit(XLEN, REG_ADDR_W);
    localparam int SRC2_LSB  = src2_lsb(XLEN, REG_ADDR_W);
    localparam int RW_BIT    = regwrite_bit(XLEN, REG_ADDR_W);
    localparam int MW_BIT    = memwrite_bit(XLEN, REG_ADDR_W);
    localparam int ALUOP_LSB = aluop_lsb(XLEN, REG_ADDR_W);

    logic [NUM_SLOTS-1:0] ready_s;
    logic [NUM_SLOTS-1:0] grant_s;
    logic                 grant_any_s;
    logic                 accept_s;
    logic [PTR_W-1:0]     rr_ptr_r;
    logic [PTR_W-1:0]     next_ptr_s;
    logic [ENTRY_W-1:0]   sel_entry_s;
    logic [ROB_IDX_W-1:0] sel_rob_idx_s;
    logic [XLEN-1:0]      aluout_s;
    logic                 unused_ctrl_s;

    logic                  out_valid_r;
    logic                  regwrite_r;
    logic [XLEN-1:0]       result_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic [ROB_IDX_W-1:0]  rob_idx_r;

    assign accept_s = !flush && (!out_valid_r || out_ready);

    // Per-slot operand readiness.
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            ready_s[i] = rs_occupied[i]
                       & rs_entry[i*ENTRY_W + SRC1_V]
                       & rs_entry[i*ENTRY_W + SRC2_V];
        end
    end

    rr_arbiter #(
        .N     (NUM_SLOTS),
        .PTR_W (PTR_W)
    ) u_arb (
        .req       (ready_s),
        .ptr       (rr_ptr_r),
        .en        (accept_s),
        .grant     (grant_s),
        .grant_any (grant_any_s),
        .next_ptr  (next_ptr_s)
    );

    // One-hot mux of the granted slot; all zeros when nothing is granted.
    always_comb begin
        sel_entry_s   = '0;
        sel_rob_idx_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (grant_s[i]) begin
                sel_entry_s   = rs_entry[i*ENTRY_W +: ENTRY_W];
                sel_rob_idx_s = rs_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            end else begin
                sel_entry_s   = sel_entry_s;
            end
        end
    end

    // Memory/branch control travels with the entry but is not acted on here.
    assign unused_ctrl_s = ^sel_entry_s[MW_BIT:RW_BIT+1];

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .aluop  (sel_entry_s[ALUOP_LSB +: ALU_OP_W]),
        .src1   (sel_entry_s[SRC1_LSB +: XLEN]),
        .src2   (sel_entry_s[SRC2_LSB +: XLEN]),
        .result (aluout_s)
    );

    // Arbitration pointer advances only past an actual grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (grant_any_s) begin
            rr_ptr_r <= next_ptr_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Output register: flush wins, a new grant replaces any drained result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            regwrite_r  <= 1'b0;
            result_r    <= '0;
            rd_r        <= '0;
            rob_idx_r   <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (grant_any_s) begin
            out_valid_r <= 1'b1;
            regwrite_r  <= sel_entry_s[RW_BIT];
            result_r    <= aluout_s;
            rd_r        <= sel_entry_s[REG_ADDR_W-1:0];
            rob_idx_r   <= sel_rob_idx_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign issue         = grant_s;
    assign out_valid     = out_valid_r;
    assign executed_inst = {regwrite_r, result_r, rd_r};
    assign out_rob_idx   = rob_idx_r;
    assign writeData     = result_r;
    assign writeAddr     = rd_r;
    // A flushed result must never reach the register file.
    assign writeEn       = out_valid_r && out_ready && !flush && regwrite_r && (rd_r != '0);

endmodule

// File: tb/tb_ex_simple_pipe.sv
// Scoreboard bench for ex_simple_pipe: stimulus pushes expected results,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_ex_simple_pipe;
    import ex_pkg::*;

    localparam int NS = 2;
    localparam int EW = 81;

    typedef struct packed {
        logic [37:0] inst;
        logic [3:0]  tag;
        logic        wen;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NS*EW-1:0] rs_entry = '0;
    logic [NS*4-1:0] rs_rob_idx = '0;
    logic [NS-1:0]   rs_occupied = '0;
    logic [NS-1:0]   issue;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [37:0]     executed_inst;
    logic [3:0]      out_rob_idx;
    logic [31:0]     writeData;
    logic [4:0]      writeAddr;
    logic            writeEn;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    ex_simple_pipe dut (
        .clk(clk), .rst(rst), .rs_entry(rs_entry), .rs_rob_idx(rs_rob_idx),
        .rs_occupied(rs_occupied), .issue(issue), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .executed_inst(executed_inst),
        .out_rob_idx(out_rob_idx), .writeData(writeData), .writeAddr(writeAddr),
        .writeEn(writeEn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [EW-1:0] mk(input logic [4:0] op, input logic rw,
                                         input logic [31:0] s1, input logic [31:0] s2,
                                         input logic [4:0] rd);
        return {op, 4'b0000, rw, s2, 1'b1, s1, 1'b1, rd};
    endfunction

    task automatic set_slot(input int s, input logic [EW-1:0] e, input logic [3:0] tag);
        rs_entry[s*EW +: EW] = e;
        rs_rob_idx[s*4 +: 4] = tag;
    endtask

    task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic [3:0] tag,
                        input logic wen);
        exp_t e;
        e.inst = {1'b1, res, rd};
        e.tag  = tag;
        e.wen  = wen;
        sb_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'(executed_inst), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("executed_inst", 64'(executed_inst), 64'(e.inst));
                check("out_rob_idx", 64'(out_rob_idx), 64'(e.tag));
                check("writeEn", 64'(writeEn), 64'(e.wen));
                check("writeData", 64'(writeData), 64'(e.inst[36:5]));
                check("writeAddr", 64'(writeAddr), 64'(e.inst[4:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [EW-1:0] g_ent [4];
    logic [31:0]   g_res [4];
    logic [1:0]    g_iss [4];

    initial begin
        // Reset state
        #3;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_writeEn", 64'(writeEn), 64'd0);
        check("reset_issue", 64'(issue), 64'd0);
        check("reset_executed_inst", 64'(executed_inst), 64'd0);
        check("reset_rob_idx", 64'(out_rob_idx), 64'd0);
        next_cycle();
        rst = 1'b0;

        // Single slot ADD 5+7 -> rd 3, tag 9
        out_ready = 1'b1;
        set_slot(0, mk(ALU_ADD, 1'b1, 32'd5, 32'd7, 5'd3), 4'd9);
        rs_occupied = 2'b01;
        @(negedge clk);
        check("single_issue", 64'(issue), 64'd1);
        push(32'd12, 5'd3, 4'd9, 1'b1);
        next_cycle();
        rs_occupied = 2'b00;
        @(negedge clk);
        check("single_out_valid", 64'(out_valid), 64'd1);
        next_cycle();

        // Alternating grants from reset, both slots refilled each cycle
        rst = 1'b1;
        #2;
        rst = 1'b0;
        g_ent[0] = mk(ALU_ADD, 1'b1, 32'd1, 32'd2, 5'd1);          g_res[0] = 32'd3;
        g_ent[1] = mk(ALU_SUB, 1'b1, 32'd10, 32'd4, 5'd2);         g_res[1] = 32'd6;
        g_ent[2] = mk(ALU_AND, 1'b1, 32'hFF, 32'h0F, 5'd4);        g_res[2] = 32'h0F;
        g_ent[3] = mk(ALU_OR, 1'b1, 32'hF0, 32'h0F, 5'd5);         g_res[3] = 32'hFF;
        g_iss[0] = 2'b01; g_iss[1] = 2'b10; g_iss[2] = 2'b01; g_iss[3] = 2'b10;
        rs_occupied = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int gs;
            gs = (k % 2);
            set_slot(gs, g_ent[k], 4'(k + 1));
            set_slot(1 - gs, mk(ALU_ADD, 1'b1, 32'd100, 32'd100, 5'd7), 4'd15);
            @(negedge clk);
            check("alt_issue", 64'(issue), 64'(g_iss[k]));
            push(g_res[k], g_ent[k][4:0], 4'(k + 1), 1'b1);
            next_cycle();
        end
        rs_occupied = 2'b00;
        next_cycle();

        // Back-pressure: hold slot0 result while slot1 waits
        set_slot(0, mk(ALU_ADD, 1'b1, 32'd20, 32'd22, 5'd6), 4'd5);
        rs_occupied = 2'b01;
        @(negedge clk);
        check("bp_first_issue", 64'(issue), 64'd1);
        push(32'd42, 5'd6, 4'd5, 1'b1);
        next_cycle();
        out_ready = 1'b0;
        set_slot(1, mk(ALU_XOR, 1'b1, 32'hAA, 32'h55, 5'd8), 4'd6);
        rs_occupied = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_stall_issue", 64'(issue), 64'd0);
            check("bp_hold_inst", 64'(executed_inst), 64'({1'b1, 32'd42, 5'd6}));
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_wen", 64'(writeEn), 64'd0);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_issue", 64'(issue), 64'd2);
        push(32'hFF, 5'd8, 4'd6, 1'b1);
        next_cycle();
        rs_occupied = 2'b00;
        next_cycle();

        // Flush while a result is held and slot0 is ready
        out_ready = 1'b0;
        set_slot(0, mk(ALU_ADD, 1'b1, 32'd1, 32'd1, 5'd9), 4'd7);
        rs_occupied = 2'b01;
        @(negedge clk);
        check("flush_pre_issue", 64'(issue), 64'd1);
        next_cycle();
        set_slot(0, mk(ALU_ADD, 1'b1, 32'd3, 32'd3, 5'd10), 4'd8);
        flush = 1'b1;
        @(negedge clk);
        check("flush_issue", 64'(issue), 64'd0);
        check("flush_wen", 64'(writeEn), 64'd0);
        next_cycle();
        flush = 1'b0;
        rs_occupied = 2'b00;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_after_wen", 64'(writeEn), 64'd0);
        next_cycle();

        // rd=0 with regwrite: SUB 3-5, no RF write (pointer at 1 wraps to slot0)
        set_slot(0, mk(ALU_SUB, 1'b1, 32'd3, 32'd5, 5'd0), 4'd10);
        rs_occupied = 2'b01;
        @(negedge clk);
        check("rd0_issue", 64'(issue), 64'd1);
        push(32'hFFFFFFFE, 5'd0, 4'd10, 1'b0);
        next_cycle();
        rs_occupied = 2'b00;
        next_cycle();

        // Asynchronous reset mid-stall
        set_slot(0, mk(ALU_ADD, 1'b1, 32'd2, 32'd2, 5'd11), 4'd11);
        rs_occupied = 2'b01;
        @(negedge clk);
        check("ar_issue", 64'(issue), 64'd1);
        next_cycle();
        out_ready = 1'b0;
        rs_occupied = 2'b00;
        @(negedge clk);
        check("ar_pre_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_valid_drop", 64'(out_valid), 64'd0);
        check("ar_inst_clear", 64'(executed_inst), 64'd0);
        #1;
        rst = 1'b0;
        next_cycle();
        out_ready = 1'b1;
        set_slot(0, mk(ALU_XOR, 1'b1, 32'h0F, 32'h01, 5'd12), 4'd12);
        set_slot(1, mk(ALU_ADD, 1'b1, 32'd100, 32'd100, 5'd7), 4'd15);
        rs_occupied = 2'b11;
        @(negedge clk);
        check("ar_ptr_restart", 64'(issue), 64'd1);
        push(32'h0E, 5'd12, 4'd12, 1'b1);
        next_cycle();
        rs_occupied = 2'b00;
        next_cycle();
        next_cycle();

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
